// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller:
// stall bus layout, canonical stall patterns and FSM state encoding.
package pipe_stall_ctrl_pkg;

  typedef logic [5:0] StallBus;

  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;

  // Hold every stage from PC up to and including 'upto'; the next stage gets a bubble.
  function automatic StallBus hold_through(input int upto);
    StallBus m;
    m = '0;
    for (int i = STALL_PC; i <= STALL_WB; i++) begin
      if (i <= upto) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam StallBus LU_STALL = hold_through(STALL_ID);
  localparam StallBus MC_STALL = hold_through(STALL_EX);

  typedef enum logic {
    IDLE    = 1'b0,
    MC_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the stall
// controller (slave).
interface pipe_stall_ctrl_if
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
);

  logic                  id_reg1_read_i;
  logic [REG_ADDR_W-1:0] id_reg1_addr_i;
  logic                  id_reg2_read_i;
  logic [REG_ADDR_W-1:0] id_reg2_addr_i;
  logic                  ex_load_i;
  logic [REG_ADDR_W-1:0] ex_wd_i;
  logic                  ex_mc_req_i;
  logic                  ex_mc_done_i;
  logic                  flush_req_i;

  StallBus               stall_o;
  logic                  flush_o;
  logic                  ex_mc_start_o;
  logic                  ex_mc_abort_o;
  logic                  mc_timeout_o;
  logic                  busy_o;
  logic [31:0]           lu_stall_cnt_o;
  logic [31:0]           mc_stall_cnt_o;

  modport master (
    output id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
           ex_load_i, ex_wd_i, ex_mc_req_i, ex_mc_done_i, flush_req_i,
    input  stall_o, flush_o, ex_mc_start_o, ex_mc_abort_o, mc_timeout_o,
           busy_o, lu_stall_cnt_o, mc_stall_cnt_o
  );

  modport slave (
    input  id_reg1_read_i, id_reg1_addr_i, id_reg2_read_i, id_reg2_addr_i,
           ex_load_i, ex_wd_i, ex_mc_req_i, ex_mc_done_i, flush_req_i,
    output stall_o, flush_o, ex_mc_start_o, ex_mc_abort_o, mc_timeout_o,
           busy_o, lu_stall_cnt_o, mc_stall_cnt_o
  );

endinterface

// File: rtl/pipe_stall_ctrl_lu_hazard_cmp.sv
// Combinational load-use comparator: a load in EX whose destination is read
// by decode cannot be forwarded in time. Writes to x0 never hazard.
module lu_hazard_cmp #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_load_i,
  input  logic [REG_ADDR_W-1:0] ex_wd_i,
  input  logic                  rd1_en_i,
  input  logic [REG_ADDR_W-1:0] rd1_addr_i,
  input  logic                  rd2_en_i,
  input  logic [REG_ADDR_W-1:0] rd2_addr_i,
  output logic                  hazard_o
);

  logic wd_live;
  logic rd1_hit;
  logic rd2_hit;

  assign wd_live  = ex_load_i && (ex_wd_i != '0);
  assign rd1_hit  = rd1_en_i && (rd1_addr_i == ex_wd_i);
  assign rd2_hit  = rd2_en_i && (rd2_addr_i == ex_wd_i);
  assign hazard_o = wd_live && (rd1_hit || rd2_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline sequencing controller: load-use stall, multi-cycle EX sequencing
// with timeout, flush arbitration. Optional stall counters under STALL_PERF_EN.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MC_MAX_CYCLES = 64,
  parameter int REG_ADDR_W    = 5
) (
  input  logic            clk,
  input  logic            rst,
  pipe_stall_ctrl_if.slave bus
);

  localparam int              CNT_W   = $clog2(MC_MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MC_MAX_CYCLES);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic              lu_hit;
  StallBus           stall_c;
  logic              flush_c;
  logic              start_c;
  logic              abort_c;

  lu_hazard_cmp #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lu_cmp (
    .ex_load_i  (bus.ex_load_i),
    .ex_wd_i    (bus.ex_wd_i),
    .rd1_en_i   (bus.id_reg1_read_i),
    .rd1_addr_i (bus.id_reg1_addr_i),
    .rd2_en_i   (bus.id_reg2_read_i),
    .rd2_addr_i (bus.id_reg2_addr_i),
    .hazard_o   (lu_hit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    stall_c   = '0;
    flush_c   = 1'b0;
    start_c   = 1'b0;
    abort_c   = 1'b0;

    if (bus.flush_req_i) begin
      flush_c = 1'b1;
      abort_c = (state_q == MC_BUSY) && !bus.ex_mc_done_i;
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.ex_mc_req_i) begin
            start_c = 1'b1;
            stall_c = MC_STALL;
            cnt_d   = CNT_W'(1);
            state_d = MC_BUSY;
          end else if (lu_hit) begin
            stall_c = LU_STALL;
          end
        end
        MC_BUSY: begin
          // Done releases the pipe in the same cycle so the result moves on to MEM.
          if (bus.ex_mc_done_i) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (cnt_q >= CNT_MAX) begin
            timeout_d = 1'b1;
            flush_c   = 1'b1;
            abort_c   = 1'b1;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            stall_c = MC_STALL;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Combinational outputs are gated so every output reads 0 the moment reset asserts.
  assign bus.stall_o       = rst ? stall_c : '0;
  assign bus.flush_o       = rst && flush_c;
  assign bus.ex_mc_start_o = rst && start_c;
  assign bus.ex_mc_abort_o = rst && abort_c;
  assign bus.mc_timeout_o  = timeout_q;
  assign bus.busy_o        = (state_q == MC_BUSY);

`ifdef STALL_PERF_EN
  logic [31:0] lu_cnt_q;
  logic [31:0] mc_cnt_q;
  logic        lu_cyc;
  logic        mc_cyc;

  assign lu_cyc = (stall_c == LU_STALL);
  assign mc_cyc = (stall_c == MC_STALL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lu_cnt_q <= '0;
      mc_cnt_q <= '0;
    end else begin
      if (lu_cyc && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + 32'd1;
      if (mc_cyc && (mc_cnt_q != '1)) mc_cnt_q <= mc_cnt_q + 32'd1;
    end
  end

  assign bus.lu_stall_cnt_o = lu_cnt_q;
  assign bus.mc_stall_cnt_o = mc_cnt_q;
`else
  assign bus.lu_stall_cnt_o = '0;
  assign bus.mc_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: load-use vector table, directed multi-cycle
// sequences, and randomized traffic against a cycle-count reference model.
module tb_pipe_stall_ctrl;

  localparam int MAXC = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.REG_ADDR_W(5)) bus ();

  pipe_stall_ctrl #(
    .MC_MAX_CYCLES (MAXC),
    .REG_ADDR_W    (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       r1e;
    logic [4:0] r1a;
    logic       r2e;
    logic [4:0] r2a;
    logic       ld;
    logic [4:0] wd;
    logic       req;
    logic       done;
    logic       fl;
  } in_t;

  typedef struct packed {
    logic       ld;
    logic [4:0] wd;
    logic       r1e;
    logic [4:0] r1a;
    logic       r2e;
    logic [4:0] r2a;
    logic [5:0] exp;
  } lu_vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: an op in flight is described by the cycle it started;
  // its age is the number of cycles elapsed since then.
  int   cyc     = 0;
  bit   m_busy  = 1'b0;
  int   m_start = 0;
  bit   m_to    = 1'b0;
  int   m_lu    = 0;
  int   m_mc    = 0;
  bit   n_busy;
  int   n_start;
  bit   n_to;
  logic [5:0] e_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic in_t mk(input logic req, input logic done, input logic fl);
    in_t v;
    v      = '0;
    v.req  = req;
    v.done = done;
    v.fl   = fl;
    return v;
  endfunction

  task automatic drive(input in_t v);
    bus.id_reg1_read_i = v.r1e;
    bus.id_reg1_addr_i = v.r1a;
    bus.id_reg2_read_i = v.r2e;
    bus.id_reg2_addr_i = v.r2a;
    bus.ex_load_i      = v.ld;
    bus.ex_wd_i        = v.wd;
    bus.ex_mc_req_i    = v.req;
    bus.ex_mc_done_i   = v.done;
    bus.flush_req_i    = v.fl;
  endtask

  task automatic chk_perf(input string tag);
`ifdef STALL_PERF_EN
    chk({tag, ".lu_cnt"}, bus.lu_stall_cnt_o, 32'(m_lu));
    chk({tag, ".mc_cnt"}, bus.mc_stall_cnt_o, 32'(m_mc));
`else
    chk({tag, ".lu_cnt"}, bus.lu_stall_cnt_o, 32'd0);
    chk({tag, ".mc_cnt"}, bus.mc_stall_cnt_o, 32'd0);
`endif
  endtask

  // Called at posedge+1: drive, let outputs settle, compare against the model.
  task automatic apply(input in_t v, input string tag);
    bit lu;
    bit ef, est, eab;
    logic [5:0] es;
    int age;
    drive(v);
    #3;
    lu  = v.ld && (v.wd != 5'd0) &&
          ((v.r1e && v.r1a == v.wd) || (v.r2e && v.r2a == v.wd));
    es  = 6'd0;
    ef  = 1'b0;
    est = 1'b0;
    eab = 1'b0;
    n_busy  = m_busy;
    n_start = m_start;
    n_to    = m_to;
    age     = cyc - m_start;
    if (v.fl) begin
      ef     = 1'b1;
      eab    = m_busy && !v.done;
      n_busy = 1'b0;
    end else if (m_busy) begin
      if (v.done) n_busy = 1'b0;
      else if (age >= MAXC) begin
        ef = 1'b1; eab = 1'b1; n_to = 1'b1; n_busy = 1'b0;
      end else es = 6'b001111;
    end else if (v.req) begin
      est = 1'b1; es = 6'b001111; n_busy = 1'b1; n_start = cyc;
    end else if (lu) begin
      es = 6'b000111;
    end
    chk({tag, ".stall"},   32'(bus.stall_o),       32'(es));
    chk({tag, ".flush"},   32'(bus.flush_o),       32'(ef));
    chk({tag, ".start"},   32'(bus.ex_mc_start_o), 32'(est));
    chk({tag, ".abort"},   32'(bus.ex_mc_abort_o), 32'(eab));
    chk({tag, ".busy"},    32'(bus.busy_o),        32'(m_busy));
    chk({tag, ".timeout"}, 32'(bus.mc_timeout_o),  32'(m_to));
    chk_perf(tag);
    e_last = es;
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    m_busy  = n_busy;
    m_start = n_start;
    m_to    = n_to;
    if (e_last == 6'b000111) m_lu++;
    if (e_last == 6'b001111) m_mc++;
    #1;
  endtask

  task automatic step(input in_t v, input string tag);
    apply(v, tag);
    advance();
  endtask

  task automatic do_reset(input in_t held, input string tag);
    drive(held);
    #1 rst = 1'b0;
    #1;
    chk({tag, ".stall"},   32'(bus.stall_o),       32'd0);
    chk({tag, ".flush"},   32'(bus.flush_o),       32'd0);
    chk({tag, ".start"},   32'(bus.ex_mc_start_o), 32'd0);
    chk({tag, ".abort"},   32'(bus.ex_mc_abort_o), 32'd0);
    chk({tag, ".busy"},    32'(bus.busy_o),        32'd0);
    chk({tag, ".timeout"}, 32'(bus.mc_timeout_o),  32'd0);
    chk({tag, ".lu_cnt"},  bus.lu_stall_cnt_o,     32'd0);
    chk({tag, ".mc_cnt"},  bus.mc_stall_cnt_o,     32'd0);
    drive('0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    m_busy = 1'b0; m_to = 1'b0; m_lu = 0; m_mc = 0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  lu_vec_t tbl [8];
  in_t     v;
  int      starts;

  initial begin
    tbl[0] = '{1'b1, 5'd3,  1'b1, 5'd3,  1'b0, 5'd0,  6'b000111};
    tbl[1] = '{1'b0, 5'd3,  1'b1, 5'd3,  1'b0, 5'd0,  6'b000000};
    tbl[2] = '{1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  6'b000000};
    tbl[3] = '{1'b1, 5'd3,  1'b0, 5'd3,  1'b0, 5'd3,  6'b000000};
    tbl[4] = '{1'b1, 5'd9,  1'b0, 5'd1,  1'b1, 5'd9,  6'b000111};
    tbl[5] = '{1'b1, 5'd7,  1'b1, 5'd6,  1'b1, 5'd8,  6'b000000};
    tbl[6] = '{1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 6'b000111};
    tbl[7] = '{1'b0, 5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 6'b000000};

    do_reset('0, "reset");

    for (int i = 0; i < 8; i++) begin
      v     = '0;
      v.ld  = tbl[i].ld;  v.wd  = tbl[i].wd;
      v.r1e = tbl[i].r1e; v.r1a = tbl[i].r1a;
      v.r2e = tbl[i].r2e; v.r2a = tbl[i].r2a;
      apply(v, "lu_tbl");
      chk("lu_tbl.vec", 32'(bus.stall_o), 32'(tbl[i].exp));
      advance();
    end

    // Multi-cycle op finishing at counter 7
    starts = 0;
    apply(mk(1, 0, 0), "mc_start");
    starts += int'(bus.ex_mc_start_o);
    advance();
    for (int i = 0; i < 6; i++) begin
      apply(mk(1, 0, 0), "mc_wait");
      starts += int'(bus.ex_mc_start_o);
      advance();
    end
    apply(mk(1, 1, 0), "mc_done");
    chk("mc_done.stall_zero", 32'(bus.stall_o), 32'd0);
    advance();
    chk("mc_start_once", 32'(starts), 32'd1);
    step(mk(0, 0, 0), "mc_after");

    // Done arriving exactly at counter == MAX wins over timeout
    step(mk(1, 0, 0), "edge_start");
    for (int i = 0; i < 7; i++) step(mk(1, 0, 0), "edge_wait");
    apply(mk(1, 1, 0), "edge_done");
    chk("edge_done.no_flush", 32'(bus.flush_o), 32'd0);
    advance();
    step(mk(0, 0, 0), "edge_after");

    // Back-to-back ops
    step(mk(1, 0, 0), "b2b_start1");
    for (int i = 0; i < 3; i++) step(mk(1, 0, 0), "b2b_wait1");
    step(mk(1, 1, 0), "b2b_done1");
    apply(mk(1, 0, 0), "b2b_start2");
    chk("b2b.second_start", 32'(bus.ex_mc_start_o), 32'd1);
    advance();
    step(mk(1, 0, 0), "b2b_wait2");
    step(mk(1, 1, 0), "b2b_done2");
    step(mk(0, 0, 0), "b2b_after");

    // Flush in the third MC_BUSY cycle, then flush coinciding with done
    step(mk(1, 0, 0), "fl_start");
    step(mk(1, 0, 0), "fl_wait");
    step(mk(1, 0, 0), "fl_wait");
    apply(mk(1, 0, 1), "fl_busy");
    chk("fl_busy.abort", 32'(bus.ex_mc_abort_o), 32'd1);
    chk("fl_busy.stall", 32'(bus.stall_o), 32'd0);
    advance();
    apply(mk(0, 0, 0), "fl_after");
    chk("fl_after.idle", 32'(bus.busy_o), 32'd0);
    advance();
    step(mk(1, 0, 0), "fld_start");
    step(mk(1, 0, 0), "fld_wait");
    apply(mk(1, 1, 1), "fld_both");
    chk("fld_both.no_abort", 32'(bus.ex_mc_abort_o), 32'd0);
    chk("fld_both.flush", 32'(bus.flush_o), 32'd1);
    advance();

    // Timeout: no done for MAXC cycles
    step(mk(1, 0, 0), "to_start");
    for (int i = 0; i < MAXC - 1; i++) step(mk(1, 0, 0), "to_wait");
    apply(mk(1, 0, 0), "to_fire");
    chk("to_fire.flush", 32'(bus.flush_o), 32'd1);
    chk("to_fire.abort", 32'(bus.ex_mc_abort_o), 32'd1);
    advance();
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0), "to_sticky");
    chk("to_sticky.flag", 32'(bus.mc_timeout_o), 32'd1);
    do_reset('0, "to_reset");

    // Asynchronous reset in the middle of an op, with the request still high
    step(mk(1, 0, 0), "rst_start");
    for (int i = 0; i < 3; i++) step(mk(1, 0, 0), "rst_wait");
    do_reset(mk(1, 0, 0), "rst_mid");
    for (int i = 0; i < 3; i++) step(mk(0, 0, 0), "rst_after");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      v      = '0;
      v.r1e  = 1'($urandom_range(0, 1));
      v.r1a  = 5'($urandom_range(0, 3));
      v.r2e  = 1'($urandom_range(0, 1));
      v.r2a  = 5'($urandom_range(0, 3));
      v.ld   = 1'($urandom_range(0, 1));
      v.wd   = 5'($urandom_range(0, 3));
      v.req  = 1'($urandom_range(0, 1));
      v.done = ($urandom_range(0, 4) == 0);
      v.fl   = ($urandom_range(0, 19) == 0);
      step(v, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core; sits beside the decode stage.
- Detects load-use hazards from the decode stage's register-read requests, which forwarding cannot resolve.
- Sequences multi-cycle EX operations (mul/div) through a start/done handshake with a timeout.
- Drives the per-stage stall vector and the pipeline flush. Flush requests come from exception/branch logic.

Parameters:
- MC_MAX_CYCLES, 64: maximum cycles a multi-cycle EX op may stay busy before timeout; legal range 2..255.
- REG_ADDR_W, 5: register-file address width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- id_reg1_read_i  input  1  decode requests reg1 from the register file.
- id_reg1_addr_i  input  REG_ADDR_W  decode reg1 address.
- id_reg2_read_i  input  1  decode requests reg2 from the register file.
- id_reg2_addr_i  input  REG_ADDR_W  decode reg2 address.
- ex_load_i  input  1  instruction in EX is a load.
- ex_wd_i  input  REG_ADDR_W  destination register of the instruction in EX.
- ex_mc_req_i  input  1  instruction in EX is a multi-cycle op; held for as long as it occupies EX.
- ex_mc_done_i  input  1  multi-cycle unit result valid this cycle.
- flush_req_i  input  1  flush the pipeline this cycle.
- stall_o  output  6  hold bits: [0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb.
- flush_o  output  1  clear all pipeline registers this cycle.
- ex_mc_start_o  output  1  one-cycle start pulse to the multi-cycle unit.
- ex_mc_abort_o  output  1  one-cycle abort pulse to the multi-cycle unit.
- mc_timeout_o  output  1  sticky timeout error flag.
- busy_o  output  1  FSM is in MC_BUSY.

Behaviour:
- Reset: all outputs 0, state IDLE, cycle counter 0, mc_timeout_o cleared. Reset assertion mid-op abandons the op silently; no abort pulse is generated.
- Stall convention:
  - stall_o[i]=1 holds stage i's register.
  - stall_o[i]=1 with stall_o[i+1]=0 injects a bubble into stage i+1.
- Load-use hazard, combinational: lu = ex_load_i && ex_wd_i!=0 && ((id_reg1_read_i && id_reg1_addr_i==ex_wd_i) || (id_reg2_read_i && id_reg2_addr_i==ex_wd_i)).
  - lu gives stall_o=6'b000111 in the same cycle.
  - The stall lasts exactly one cycle, because the bubble leaves EX without a load.
- FSM states: IDLE, MC_BUSY.
  - IDLE with ex_mc_req_i=1 and no flush: ex_mc_start_o=1, stall_o=6'b001111, counter<=1, go to MC_BUSY.
  - MC_BUSY with ex_mc_done_i=0: stall_o=6'b001111, counter increments.
  - MC_BUSY with ex_mc_done_i=1: stall_o=0 in that same cycle so the result advances to MEM; counter<=0; go to IDLE. ex_mc_req_i is ignored while in MC_BUSY.
  - MC_BUSY with counter==MC_MAX_CYCLES and no done: mc_timeout_o<=1 (sticky); flush_o=1; ex_mc_abort_o=1; stall_o=0; go to IDLE.
- Priority: flush_req_i > multi-cycle > load-use.
  - While in MC_BUSY, the load-use stall is subsumed.
  - flush_req_i=1 forces: flush_o=1, stall_o=0, ex_mc_start_o=0, next state IDLE, counter<=0.
  - ex_mc_abort_o=1 if the FSM was in MC_BUSY and ex_mc_done_i=0 that cycle.
  - flush together with done: no abort.
- Output timing:
  - stall_o and flush_o are combinational from state plus inputs.
  - ex_mc_start_o and ex_mc_abort_o are combinational pulses, never high for 2 consecutive cycles.
- Counter width: $clog2(MC_MAX_CYCLES+1); it never wraps.

Optional Feature:
STALL_PERF_EN
- Defined: adds lu_stall_cnt_o[31:0] and mc_stall_cnt_o[31:0].
  - Each is a saturating count of cycles with load-use stall, and of cycles with multi-cycle stall, respectively.
  - Cleared by reset only.
- Undefined: both ports are present but tied to 0, with no counter flops.

Decomposition:
- Shared package / defines file:
  - StallBus 5:0 and the stall bit index constants (STALL_PC..STALL_WB).
  - Stall patterns LU_STALL=6'b000111 and MC_STALL=6'b001111.
  - FSM state encoding.
- Sub-module: lu_hazard_cmp, the combinational load-use comparator. It is reusable by a future dual-issue decode.

Test Plan:
1. Load x3 in EX; decode reads reg1=x3 -> stall_o=000111 for exactly 1 cycle, then 000000. Same with ex_wd_i=0 -> no stall.
2. ex_mc_req_i high; done asserted 10 cycles after start -> ex_mc_start_o pulses once; stall_o=001111 until the done cycle; busy_o falls after the done edge.
3. MC_MAX_CYCLES=8, done never asserted -> at counter 8: flush_o=1 and ex_mc_abort_o=1 for 1 cycle; mc_timeout_o stays 1 until rst=0.
4. flush_req_i in cycle 3 of MC_BUSY -> abort pulse, stall_o=0, state IDLE. flush_req_i together with done -> no abort.
5. Back-to-back multi-cycle ops (next op enters EX the cycle after done) -> second start pulse 1 cycle after the first done.
6. rst pulled low mid-MC_BUSY -> all outputs 0 immediately (asynchronous); after release, FSM IDLE and no spurious start pulse.
